// File: rtl/bsg_fifo_rolly_replay_ctrl.sv
// Replay sequencer for a rollback-capable FIFO: forwards entries, tracks uncommitted
// reads, turns consumer ack/nack into deq/roll, backs off after a roll, aborts on repeated failure.
module bsg_fifo_rolly_replay_ctrl #(
    parameter int els_p       = 8,
    parameter int max_retry_p = 3,
    parameter int retry_gap_p = 2,
    localparam int infl_w_lp  = $clog2(els_p + 1),
    localparam int retry_w_lp = $clog2(max_retry_p + 1),
    localparam int gap_w_lp   = (retry_gap_p > 0) ? $clog2(retry_gap_p + 1) : 1
) (
    input  logic                  clk_i,
    input  logic                  reset_n_i,
    input  logic                  fifo_v_i,
    output logic                  fifo_yumi_o,
    output logic                  fifo_deq_v_o,
    output logic                  fifo_roll_v_o,
    output logic                  fifo_clr_v_o,
    output logic                  v_o,
    input  logic                  ready_i,
    input  logic                  ack_v_i,
    input  logic                  nack_v_i,
    input  logic                  flush_i,
    output logic [infl_w_lp-1:0]  inflight_o,
    output logic [retry_w_lp-1:0] retry_cnt_o,
    output logic                  abort_o,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        st_run     = 2'd0,
        st_backoff = 2'd1,
        st_abort   = 2'd2
    } state_e;

    localparam logic [infl_w_lp-1:0]  els_lp       = infl_w_lp'(els_p);
    localparam logic [infl_w_lp-1:0]  infl_one_lp  = infl_w_lp'(1);
    localparam logic [retry_w_lp:0]   retry_lim_lp = (retry_w_lp + 1)'(max_retry_p);
    localparam logic [gap_w_lp-1:0]   gap_init_lp  = gap_w_lp'(retry_gap_p);
    localparam logic [gap_w_lp-1:0]   gap_one_lp   = gap_w_lp'(1);

    state_e                state_r, state_n_s;
    logic [infl_w_lp-1:0]  inflight_r, inflight_n_s;
    logic [retry_w_lp-1:0] retry_r, retry_n_s;
    logic [gap_w_lp-1:0]   gap_r, gap_n_s;

    logic                  v_s, yumi_s, deq_s, roll_s, abort_s;
    logic                  ack_eff_s, nack_eff_s;
    logic [infl_w_lp-1:0]  left_s;
    logic [retry_w_lp:0]   retry_inc_s;

    // Next-state and per-cycle strobe decode from current registers and consumer inputs.
    always_comb begin
        state_n_s    = state_r;
        inflight_n_s = inflight_r;
        retry_n_s    = retry_r;
        gap_n_s      = gap_r;
        v_s          = 1'b0;
        yumi_s       = 1'b0;
        deq_s        = 1'b0;
        roll_s       = 1'b0;
        abort_s      = 1'b0;
        ack_eff_s    = 1'b0;
        nack_eff_s   = 1'b0;
        left_s       = inflight_r;
        retry_inc_s  = {1'b0, retry_r} + {{retry_w_lp{1'b0}}, 1'b1};
        case (state_r)
            st_run: begin
                v_s        = fifo_v_i & (inflight_r < els_lp) & ~nack_v_i;
                yumi_s     = v_s & ready_i;
                ack_eff_s  = ack_v_i & (inflight_r != {infl_w_lp{1'b0}});
                left_s     = inflight_r - {{(infl_w_lp-1){1'b0}}, ack_eff_s};
                nack_eff_s = nack_v_i & (left_s != {infl_w_lp{1'b0}});
                deq_s      = ack_eff_s;
                if (nack_eff_s) begin
                    if (retry_inc_s < retry_lim_lp) begin
                        roll_s       = 1'b1;
                        inflight_n_s = {infl_w_lp{1'b0}};
                        retry_n_s    = retry_inc_s[retry_w_lp-1:0];
                        if (retry_gap_p != 0) begin
                            state_n_s = st_backoff;
                            gap_n_s   = gap_init_lp;
                        end else begin
                            state_n_s = st_run;
                        end
                    end else begin
                        // Too many replays of the head group: drop it rather than roll again.
                        abort_s      = 1'b1;
                        retry_n_s    = {retry_w_lp{1'b0}};
                        inflight_n_s = left_s;
                        state_n_s    = st_abort;
                    end
                end else begin
                    if (yumi_s && !ack_eff_s) begin
                        inflight_n_s = inflight_r + infl_one_lp;
                    end else if (ack_eff_s && !yumi_s) begin
                        inflight_n_s = inflight_r - infl_one_lp;
                    end else begin
                        inflight_n_s = inflight_r;
                    end
                    if (ack_eff_s) begin
                        retry_n_s = {retry_w_lp{1'b0}};
                    end else begin
                        retry_n_s = retry_r;
                    end
                end
            end
            st_backoff: begin
                gap_n_s = gap_r - gap_one_lp;
                if (gap_r <= gap_one_lp) begin
                    state_n_s = st_run;
                end else begin
                    state_n_s = st_backoff;
                end
            end
            st_abort: begin
                // Commit the failed entries one per cycle so the FIFO frees them for good.
                if (inflight_r != {infl_w_lp{1'b0}}) begin
                    deq_s        = 1'b1;
                    inflight_n_s = inflight_r - infl_one_lp;
                end else begin
                    inflight_n_s = inflight_r;
                end
                if (inflight_r <= infl_one_lp) begin
                    state_n_s = st_run;
                end else begin
                    state_n_s = st_abort;
                end
            end
            default: begin
                state_n_s    = st_run;
                inflight_n_s = {infl_w_lp{1'b0}};
                retry_n_s    = {retry_w_lp{1'b0}};
                gap_n_s      = {gap_w_lp{1'b0}};
            end
        endcase
    end

    // Sequencer state and counters.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_r    <= st_run;
            inflight_r <= {infl_w_lp{1'b0}};
            retry_r    <= {retry_w_lp{1'b0}};
            gap_r      <= {gap_w_lp{1'b0}};
        end else begin
            state_r    <= state_n_s;
            inflight_r <= inflight_n_s;
            retry_r    <= retry_n_s;
            gap_r      <= gap_n_s;
        end
    end

    // Strobes are forced low while reset is held so the FIFO sees nothing mid-reset.
    assign v_o           = v_s & reset_n_i;
    assign fifo_yumi_o   = yumi_s & reset_n_i;
    assign fifo_deq_v_o  = deq_s & reset_n_i;
    assign fifo_roll_v_o = roll_s & reset_n_i;
    assign fifo_clr_v_o  = flush_i & reset_n_i;
    assign abort_o       = abort_s & reset_n_i;
    assign busy_o        = (state_r != st_run) & reset_n_i;
    assign inflight_o    = inflight_r;
    assign retry_cnt_o   = retry_r;

endmodule
